writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Parametrised second-generation writeback/condition stage.
- Sits between the memory access stage and the register file and PC logic.
- Decodes the instruction leaving the memory stage and issues the matching register-file write, immediate write, ALU cycle, status write and jump strobes.
- Adds over the previous stage: a valid/ready handshake, a multi-cycle wait on memory load data, post-jump shadow squashing, and a configurable datapath width.

Parameters:
- DATA_WIDTH, 32, register/data width; must be >= 32. Long loads are extended from bit 31 to this width.
- SHADOW_SLOTS, 2, number of accepted instructions squashed after a taken jump (0..7).
- LOAD_TIMEOUT, 15, WAIT_DATA cycles before a bus error; used only with WRITEBACK_LOAD_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  inbound_instruction and return_address are valid
- in_ready  out  1  stage can accept; combinational: 1 in IDLE, 0 in WAIT_DATA
- inbound_instruction  in  32  instruction word: opcode[31:27], type[26:25], signed[24], reg[23:20], cond[15:12], imm[15:0]
- return_address  in  DATA_WIDTH  PC value saved by branch/jump-with-link
- data_in  in  DATA_WIDTH  memory read data
- data_valid  in  1  data_in valid this cycle
- alu_carry, alu_zero, alu_neg, alu_over  in  1 each  status register flags
- write_index  out  4  destination register
- write  out  1  register-file write strobe
- write_data  out  DATA_WIDTH  register-file write data
- write_immediate  out  1  immediate write strobe
- write_immediate_data  out  16  immediate value
- write_immediate_type  out  2  immediate type
- alu_cycle  out  1  ALU result writeback strobe
- status_register_write  out  1  status register update strobe
- jump  out  1  taken branch/jump strobe
- bus_error  out  1  load timeout strobe

Behaviour:
- Reset values:
  - Strobes (write, write_immediate, alu_cycle, status_register_write, jump, bus_error) = 0.
  - write_index = 0, write_immediate_data = 0, write_immediate_type = IT_UNSIGNED, write_data = 0.
  - State = IDLE, shadow counter = 0, timeout counter = 0.
- Handshake and strobes:
  - Accept = in_valid & in_ready.
  - All outputs are registered and appear on the cycle after acceptance (latency 1).
  - Every strobe defaults to 0 each cycle, so each strobe is a single-cycle pulse.
- Condition evaluation:
  - Combinational from cond[15:12] and the flags, using COND_AL/EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE as ARM.
  - Undefined codes evaluate false.
- Register write data:
  - write_index <= inbound_instruction[23:20] on every accept, including squashed instructions.
  - write_data holds its value when not written.
- OPCODE_LOADI: write_immediate = 1; write_immediate_type = [26:25]; write_immediate_data = [15:0].
- OPCODE_LOAD / OPCODE_LOADR:
  - If data_valid is high in the accept cycle: write = 1 next cycle, extended data, state stays IDLE.
  - Otherwise: go to WAIT_DATA. On the first cycle with data_valid, capture and extend data_in, pulse write next cycle, return to IDLE.
  - Extension: CW_BYTE from bits [7:0], CW_WORD from [15:0], anything else from [31:0]. Sign-extend if bit 24 = 1, else zero-extend, up to DATA_WIDTH.
- OPCODE_ALU / ALUM / ALUMI: alu_cycle = 1, status_register_write = 1, write = 1.
- OPCODE_BRANCH / OPCODE_JUMP:
  - Condition true: jump = 1; if bit 24 = 1, also write = 1 with write_data = return_address.
  - Condition true: shadow counter <= SHADOW_SLOTS.
  - Condition false: no strobes.
- Other opcodes: no strobes.
- Shadow squash:
  - While the shadow counter is nonzero, each accepted instruction produces no strobes and decrements the counter.
  - A taken jump inside the shadow is itself squashed and does not reload the counter.
  - Cycles without in_valid do not decrement the counter.
- WAIT_DATA state:
  - in_ready = 0 and in_valid is ignored.
  - data_valid while IDLE with no load being accepted is ignored.
- Reset asserted mid-WAIT_DATA or mid-shadow: all state returns to reset values on that clock edge; no strobe is issued.

Optional Feature:
- Macro: WRITEBACK_LOAD_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_DATA and increments each cycle without data_valid.
  - On reaching LOAD_TIMEOUT: bus_error pulses 1 for one cycle, no write, state returns to IDLE.
  - data_valid in the same cycle the count is reached wins: normal write, no bus_error.
- Undefined: no counter; WAIT_DATA persists until data_valid; bus_error is tied to 0.

Test Plan:
- LOADI, type = IT_SIGNED, imm = 16'h8001, reg 3 -> next cycle write_immediate = 1, data = 16'h8001, type = IT_SIGNED, write_index = 3; all other strobes 0.
- LOAD, CW_BYTE, signed, data_valid three cycles late with data_in = 32'h000000F0 -> in_ready = 0 for 3 cycles, then write = 1 with write_data = 32'hFFFFFFF0; repeat unsigned -> 32'h000000F0.
- BRANCH, COND_EQ, bit 24 = 1, alu_zero = 1, return_address = 32'h100 -> jump = 1, write = 1, write_data = 32'h100; the next 2 accepted ALU ops produce no strobes; the third ALU op gives alu_cycle = 1.
- JUMP, COND_GT, alu_zero = 0, neg = 1, over = 0 -> no jump, no write; the following instruction is not squashed.
- Reset asserted during WAIT_DATA -> next cycle in_ready = 1, all strobes 0, no write on a late data_valid.
- With WRITEBACK_LOAD_TIMEOUT_EN and LOAD_TIMEOUT = 4, LOAD with no data_valid -> bus_error pulses once after 4 wait cycles, write stays 0, in_ready returns to 1.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: decodes the instruction leaving the memory stage and issues
// register-file, immediate, ALU, status and jump strobes one cycle after acceptance.
// Optional load timeout: define WRITEBACK_LOAD_TIMEOUT_EN to enable bus_error.
module writeback_stage #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned SHADOW_SLOTS = 2,
   parameter int unsigned LOAD_TIMEOUT = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           inbound_instruction,
   input  logic [DATA_WIDTH-1:0] return_address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  alu_carry,
   input  logic                  alu_zero,
   input  logic                  alu_neg,
   input  logic                  alu_over,
   output logic [3:0]            write_index,
   output logic                  write,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_immediate,
   output logic [15:0]           write_immediate_data,
   output logic [1:0]            write_immediate_type,
   output logic                  alu_cycle,
   output logic                  status_register_write,
   output logic                  jump,
   output logic                  bus_error
);

   localparam logic [4:0] OPCODE_LOAD   = 5'd1;
   localparam logic [4:0] OPCODE_LOADR  = 5'd2;
   localparam logic [4:0] OPCODE_LOADI  = 5'd3;
   localparam logic [4:0] OPCODE_ALU    = 5'd4;
   localparam logic [4:0] OPCODE_ALUM   = 5'd5;
   localparam logic [4:0] OPCODE_ALUMI  = 5'd6;
   localparam logic [4:0] OPCODE_BRANCH = 5'd7;
   localparam logic [4:0] OPCODE_JUMP   = 5'd8;

   localparam logic [1:0] IT_UNSIGNED = 2'd0;
   localparam logic [1:0] CW_BYTE     = 2'd1;
   localparam logic [1:0] CW_WORD     = 2'd2;

   localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14;

   typedef enum logic [0:0] {StIdle, StWaitData} state_e;

   state_e                state_q, state_d;
   logic [2:0]            shadow_q, shadow_d;
   logic [1:0]            load_cw_q, load_cw_d;
   logic                  load_signed_q, load_signed_d;
   logic [3:0]            write_index_d;
   logic [DATA_WIDTH-1:0] write_data_d;
   logic [15:0]           imm_data_d;
   logic [1:0]            imm_type_d;
   logic                  write_d, write_immediate_d, alu_cycle_d, status_write_d, jump_d;
   logic                  bus_error_d;
   logic                  accept;
   logic                  cond_true;
   logic [4:0]            opcode;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
   logic [15:0]           timeout_q, timeout_d;
`endif

   // Bits that never reach any output; folded here to keep lint quiet.
   logic unused_bits;
   assign unused_bits = ^{inbound_instruction[19:16], data_in[DATA_WIDTH-1:31]};

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [1:0] cw, input logic sgn);
      logic [DATA_WIDTH-1:0] r;
      if (cw == CW_BYTE) begin
         r = (sgn && d[7]) ? '1 : '0;
         r[7:0] = d[7:0];
      end else if (cw == CW_WORD) begin
         r = (sgn && d[15]) ? '1 : '0;
         r[15:0] = d[15:0];
      end else begin
         r = (sgn && d[31]) ? '1 : '0;
         r[31:0] = d[31:0];
      end
      return r;
   endfunction

   assign opcode   = inbound_instruction[31:27];
   assign in_ready = (state_q == StIdle);
   assign accept   = in_valid & in_ready;

   // ARM-style condition evaluation; undefined code 15 is false.
   always_comb begin
      cond_true = 1'b0;
      case (inbound_instruction[15:12])
         COND_EQ: cond_true = alu_zero;
         COND_NE: cond_true = ~alu_zero;
         COND_CS: cond_true = alu_carry;
         COND_CC: cond_true = ~alu_carry;
         COND_MI: cond_true = alu_neg;
         COND_PL: cond_true = ~alu_neg;
         COND_VS: cond_true = alu_over;
         COND_VC: cond_true = ~alu_over;
         COND_HI: cond_true = alu_carry & ~alu_zero;
         COND_LS: cond_true = ~alu_carry | alu_zero;
         COND_GE: cond_true = (alu_neg == alu_over);
         COND_LT: cond_true = (alu_neg != alu_over);
         COND_GT: cond_true = ~alu_zero & (alu_neg == alu_over);
         COND_LE: cond_true = alu_zero | (alu_neg != alu_over);
         COND_AL: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d           = state_q;
      shadow_d          = shadow_q;
      load_cw_d         = load_cw_q;
      load_signed_d     = load_signed_q;
      write_index_d     = write_index;
      write_data_d      = write_data;
      imm_data_d        = write_immediate_data;
      imm_type_d        = write_immediate_type;
      write_d           = 1'b0;
      write_immediate_d = 1'b0;
      alu_cycle_d       = 1'b0;
      status_write_d    = 1'b0;
      jump_d            = 1'b0;
      bus_error_d       = 1'b0;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
      timeout_d         = timeout_q;
`endif
      case (state_q)
         StIdle: begin
            if (accept) begin
               write_index_d = inbound_instruction[23:20];
               if (shadow_q != 3'd0) begin
                  // Squashed shadow slot: no side effects beyond the index.
                  shadow_d = shadow_q - 3'd1;
               end else begin
                  case (opcode)
                     OPCODE_LOADI: begin
                        write_immediate_d = 1'b1;
                        imm_type_d        = inbound_instruction[26:25];
                        imm_data_d        = inbound_instruction[15:0];
                     end
                     OPCODE_LOAD, OPCODE_LOADR: begin
                        load_cw_d     = inbound_instruction[26:25];
                        load_signed_d = inbound_instruction[24];
                        if (data_valid) begin
                           write_d      = 1'b1;
                           write_data_d = extend(data_in, inbound_instruction[26:25],
                                                 inbound_instruction[24]);
                        end else begin
                           state_d = StWaitData;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
                           timeout_d = '0;
`endif
                        end
                     end
                     OPCODE_ALU, OPCODE_ALUM, OPCODE_ALUMI: begin
                        alu_cycle_d    = 1'b1;
                        status_write_d = 1'b1;
                        write_d        = 1'b1;
                     end
                     OPCODE_BRANCH, OPCODE_JUMP: begin
                        if (cond_true) begin
                           jump_d   = 1'b1;
                           shadow_d = 3'(SHADOW_SLOTS);
                           if (inbound_instruction[24]) begin
                              write_d      = 1'b1;
                              write_data_d = return_address;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         StWaitData: begin
            if (data_valid) begin
               write_d      = 1'b1;
               write_data_d = extend(data_in, load_cw_q, load_signed_q);
               state_d      = StIdle;
            end
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
            else if (timeout_q == 16'(LOAD_TIMEOUT - 1)) begin
               bus_error_d = 1'b1;
               state_d     = StIdle;
            end else begin
               timeout_d = timeout_q + 16'd1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q               <= StIdle;
         shadow_q              <= 3'd0;
         load_cw_q             <= 2'd0;
         load_signed_q         <= 1'b0;
         write_index           <= 4'd0;
         write_data            <= '0;
         write_immediate_data  <= 16'd0;
         write_immediate_type  <= IT_UNSIGNED;
         write                 <= 1'b0;
         write_immediate       <= 1'b0;
         alu_cycle             <= 1'b0;
         status_register_write <= 1'b0;
         jump                  <= 1'b0;
         bus_error             <= 1'b0;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
         timeout_q             <= 16'd0;
`endif
      end else begin
         state_q               <= state_d;
         shadow_q              <= shadow_d;
         load_cw_q             <= load_cw_d;
         load_signed_q         <= load_signed_d;
         write_index           <= write_index_d;
         write_data            <= write_data_d;
         write_immediate_data  <= imm_data_d;
         write_immediate_type  <= imm_type_d;
         write                 <= write_d;
         write_immediate       <= write_immediate_d;
         alu_cycle             <= alu_cycle_d;
         status_register_write <= status_write_d;
         jump                  <= jump_d;
         bus_error             <= bus_error_d;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
         timeout_q             <= timeout_d;
`endif
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage; exercises the load timeout when
// WRITEBACK_LOAD_TIMEOUT_EN is defined.
module tb_writeback_stage;

`ifdef WRITEBACK_LOAD_TIMEOUT_EN
   localparam int unsigned TbTimeout = 4;
`else
   localparam int unsigned TbTimeout = 15;
`endif

   localparam logic [4:0] OpNop = 5'd0, OpLoad = 5'd1, OpLoadi = 5'd3, OpAlu = 5'd4;
   localparam logic [4:0] OpBranch = 5'd7, OpJump = 5'd8;
   localparam logic [1:0] ItSigned = 2'd1, CwByte = 2'd1, CwWord = 2'd2, CwLong = 2'd0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inbound_instruction = '0;
   logic [31:0] return_address = '0;
   logic [31:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        alu_carry = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0, alu_over = 1'b0;
   logic [3:0]  write_index;
   logic        write;
   logic [31:0] write_data;
   logic        write_immediate;
   logic [15:0] write_immediate_data;
   logic [1:0]  write_immediate_type;
   logic        alu_cycle, status_register_write, jump, bus_error;

   int checks = 0;
   int failures = 0;

   writeback_stage #(
      .DATA_WIDTH  (32),
      .SHADOW_SLOTS(2),
      .LOAD_TIMEOUT(TbTimeout)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .inbound_instruction  (inbound_instruction),
      .return_address       (return_address),
      .data_in              (data_in),
      .data_valid           (data_valid),
      .alu_carry            (alu_carry),
      .alu_zero             (alu_zero),
      .alu_neg              (alu_neg),
      .alu_over             (alu_over),
      .write_index          (write_index),
      .write                (write),
      .write_data           (write_data),
      .write_immediate      (write_immediate),
      .write_immediate_data (write_immediate_data),
      .write_immediate_type (write_immediate_type),
      .alu_cycle            (alu_cycle),
      .status_register_write(status_register_write),
      .jump                 (jump),
      .bus_error            (bus_error)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] typ,
                                      input logic s, input logic [3:0] rg,
                                      input logic [15:0] low);
      return {op, typ, s, rg, 4'h0, low};
   endfunction

   // Present one instruction for exactly one accept edge.
   task automatic issue(input logic [31:0] instr);
      inbound_instruction = instr;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_strobes(input string tag, input logic [5:0] exp);
      check_eq(tag, {58'd0, write, write_immediate, alu_cycle, status_register_write, jump,
                     bus_error}, {58'd0, exp});
   endtask

   initial begin
      step();
      step();
      reset = 1'b0;
      check_strobes("reset_strobes", 6'b000000);
      check_eq("reset_index", write_index, 0);
      check_eq("reset_data", write_data, 0);
      check_eq("reset_imm_type", write_immediate_type, 0);
      check_eq("reset_imm_data", write_immediate_data, 0);
      check_eq("reset_ready", in_ready, 1);

      // LOADI signed immediate.
      issue(mk(OpLoadi, ItSigned, 1'b0, 4'd3, 16'h8001));
      check_strobes("loadi_strobes", 6'b010000);
      check_eq("loadi_data", write_immediate_data, 16'h8001);
      check_eq("loadi_type", write_immediate_type, ItSigned);
      check_eq("loadi_index", write_index, 3);
      step();
      check_strobes("loadi_pulse", 6'b000000);

      // LOAD byte signed, data three cycles late; in_valid during wait is ignored.
      issue(mk(OpLoad, CwByte, 1'b1, 4'd5, 16'h0000));
      inbound_instruction = mk(OpAlu, 2'd0, 1'b0, 4'd9, 16'h0000);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("wait_ready", in_ready, 0);
         check_strobes("wait_strobes", 6'b000000);
         if (i == 2) begin
            data_valid = 1'b1;
            data_in = 32'h0000_00F0;
         end
         step();
      end
      in_valid = 1'b0;
      data_valid = 1'b0;
      check_strobes("ldb_s_strobes", 6'b100000);
      check_eq("ldb_s_data", write_data, 32'hFFFF_FFF0);
      check_eq("ldb_s_index", write_index, 5);
      check_eq("ldb_s_ready", in_ready, 1);

      // LOAD byte unsigned, late data.
      issue(mk(OpLoad, CwByte, 1'b0, 4'd6, 16'h0000));
      step();
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      check_eq("ldb_u_data", write_data, 32'h0000_00F0);
      check_strobes("ldb_u_strobes", 6'b100000);

      // Same-cycle data: word signed and long signed.
      data_valid = 1'b1;
      data_in = 32'h1234_8123;
      issue(mk(OpLoad, CwWord, 1'b1, 4'd7, 16'h0000));
      check_eq("ldw_s_data", write_data, 32'hFFFF_8123);
      check_eq("ldw_s_ready", in_ready, 1);
      data_in = 32'h8000_0001;
      issue(mk(OpLoad, CwLong, 1'b0, 4'd7, 16'h0000));
      check_eq("ldl_u_data", write_data, 32'h8000_0001);
      data_valid = 1'b0;
      // data_valid while idle without a load is ignored.
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      check_strobes("idle_dv_strobes", 6'b000000);

      // BRANCH EQ with link, then shadow squash of two accepts.
      alu_zero = 1'b1;
      return_address = 32'h100;
      issue(mk(OpBranch, 2'd0, 1'b1, 4'd14, {4'd0, 12'h000}));
      check_strobes("br_strobes", 6'b100010);
      check_eq("br_data", write_data, 32'h100);
      check_eq("br_index", write_index, 14);
      issue(mk(OpAlu, 2'd0, 1'b0, 4'd2, 16'h0000));
      check_strobes("shadow1_strobes", 6'b000000);
      check_eq("shadow1_index", write_index, 2);
      step();
      issue(mk(OpBranch, 2'd0, 1'b1, 4'd4, {4'd14, 12'h000}));
      check_strobes("shadow2_strobes", 6'b000000);
      issue(mk(OpAlu, 2'd0, 1'b0, 4'd8, 16'h0000));
      check_strobes("post_shadow_alu", 6'b101100);
      check_eq("alu_hold_data", write_data, 32'h100);

      // JUMP GT false (z=0, n=1, v=0); next instruction not squashed.
      alu_zero = 1'b0;
      alu_neg = 1'b1;
      alu_over = 1'b0;
      issue(mk(OpJump, 2'd0, 1'b1, 4'd7, {4'd12, 12'h000}));
      check_strobes("jgt_strobes", 6'b000000);
      issue(mk(OpAlu, 2'd0, 1'b0, 4'd1, 16'h0000));
      check_strobes("jgt_next_alu", 6'b101100);
      issue(mk(OpJump, 2'd0, 1'b1, 4'd7, {4'd15, 12'h000}));
      check_strobes("jnv_strobes", 6'b000000);
      // JUMP LT true without link.
      issue(mk(OpJump, 2'd0, 1'b0, 4'd7, {4'd11, 12'h000}));
      check_strobes("jlt_strobes", 6'b000010);
      issue(mk(OpNop, 2'd0, 1'b0, 4'd0, 16'h0000));
      issue(mk(OpNop, 2'd0, 1'b0, 4'd0, 16'h0000));

      // Reset during WAIT_DATA.
      issue(mk(OpLoad, CwByte, 1'b0, 4'd9, 16'h0000));
      check_eq("rst_wait_ready0", in_ready, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_wait_ready1", in_ready, 1);
      check_strobes("rst_wait_strobes", 6'b000000);
      check_eq("rst_wait_index", write_index, 0);
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      check_strobes("rst_late_dv", 6'b000000);

      // Load with no data: timeout when enabled, otherwise waits indefinitely.
      issue(mk(OpLoad, CwByte, 1'b0, 4'd10, 16'h0000));
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         check_eq("to_wait_ready", in_ready, 0);
         check_strobes("to_wait_strobes", 6'b000000);
         step();
      end
      check_strobes("to_bus_error", 6'b000001);
      check_eq("to_ready", in_ready, 1);
      step();
      check_strobes("to_pulse", 6'b000000);
`else
      for (int i = 0; i < 20; i++) begin
         step();
      end
      check_eq("nto_ready", in_ready, 0);
      check_strobes("nto_strobes", 6'b000000);
      data_valid = 1'b1;
      data_in = 32'h0000_0055;
      step();
      data_valid = 1'b0;
      check_strobes("nto_write", 6'b100000);
      check_eq("nto_data", write_data, 32'h0000_0055);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
